// File: rtl/sys_tx_ctrl.sv
// sys_tx_ctrl: serialises REG (1 byte) and ALU (2 byte, LSB first) send requests onto
// the UART TX parallel interface, with one pending slot per source and a SEND timeout.
module sys_tx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    UART_TX_REG_SEND,
  input  logic                    UART_TX_ALU_SEND,
  input  logic [DATA_WIDTH-1:0]   reg_data_tx,
  input  logic [2*DATA_WIDTH-1:0] alu_data_tx,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    tx_ctrl_busy,
  output logic                    frame_drop,
  output logic                    timeout_err
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] data_q, data_d, hi_q, hi_d, reg_buf_q, reg_buf_d;
  logic [2*DW-1:0] alu_buf_q, alu_buf_d, alu_src;
  logic valid_q, valid_d, more_q, more_d;
  logic reg_pend_q, reg_pend_d, alu_pend_q, alu_pend_d;
  logic drop_q, drop_d, tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle, no_pulse, go_reg_new, go_alu_new, go_reg_pend, go_alu_pend;
  // fresh pulses beat pending requests; REG beats ALU in both classes
  assign idle        = state_q == IDLE;
  assign no_pulse    = !UART_TX_REG_SEND && !UART_TX_ALU_SEND;
  assign go_reg_new  = idle && UART_TX_REG_SEND;
  assign go_alu_new  = idle && UART_TX_ALU_SEND && !UART_TX_REG_SEND;
  assign go_reg_pend = idle && no_pulse && reg_pend_q;
  assign go_alu_pend = idle && no_pulse && !reg_pend_q && alu_pend_q;
  assign alu_src     = go_alu_new ? alu_data_tx : alu_buf_q;
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    hi_d       = hi_q;
    valid_d    = valid_q;
    more_d     = more_q;
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
    reg_pend_d = reg_pend_q && !go_reg_pend;
    reg_buf_d  = reg_buf_q;
    alu_pend_d = alu_pend_q && !go_alu_pend;
    alu_buf_d  = alu_buf_q;
    drop_d     = (UART_TX_REG_SEND && !go_reg_new && reg_pend_d) ||
                 (UART_TX_ALU_SEND && !go_alu_new && alu_pend_d);
    if (UART_TX_REG_SEND && !go_reg_new) begin
      reg_pend_d = 1'b1;
      reg_buf_d  = reg_data_tx;
    end
    if (UART_TX_ALU_SEND && !go_alu_new) begin
      alu_pend_d = 1'b1;
      alu_buf_d  = alu_data_tx;
    end
    case (state_q)
      IDLE: begin
        if (go_reg_new || go_reg_pend) begin
          data_d  = go_reg_new ? reg_data_tx : reg_buf_q;
          valid_d = 1'b1;
          more_d  = 1'b0;
          cnt_d   = '0;
          state_d = SEND;
        end else if (go_alu_new || go_alu_pend) begin
          data_d  = alu_src[DW-1:0];
          hi_d    = alu_src[2*DW-1:DW];
          valid_d = 1'b1;
          more_d  = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (TX_BUSY) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          more_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          data_d  = more_q ? hi_q : data_q;
          valid_d = more_q;
          more_d  = 1'b0;
          state_d = more_q ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      hi_q       <= '0;
      valid_q    <= 1'b0;
      more_q     <= 1'b0;
      cnt_q      <= '0;
      reg_pend_q <= 1'b0;
      reg_buf_q  <= '0;
      alu_pend_q <= 1'b0;
      alu_buf_q  <= '0;
      drop_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      hi_q       <= hi_d;
      valid_q    <= valid_d;
      more_q     <= more_d;
      cnt_q      <= cnt_d;
      reg_pend_q <= reg_pend_d;
      reg_buf_q  <= reg_buf_d;
      alu_pend_q <= alu_pend_d;
      alu_buf_q  <= alu_buf_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
    end
  end
  assign TX_P_DATA     = data_q;
  assign TX_DATA_VALID = valid_q;
  assign frame_drop    = drop_q;
  assign timeout_err   = tmo_q;
  assign tx_ctrl_busy  = !idle || reg_pend_q || alu_pend_q;
endmodule
